// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: frame sequencer for the 3-row line buffer (FIFO reset, pixel gating, flush, window coordinates); macro WIN_BORDER_FLAG_EN adds win_border
module line_buffer_ctrl #(
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250,
  parameter int RST_CYCLES = 8,
  parameter int FLUSH_ROWS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       rst_fifo,
  input  logic       fifo_rst_busy,
  output logic       lb_valid_in,
  output logic       rd_en_all,
  output logic       win_valid,
  output logic [8:0] win_col,
  output logic [8:0] win_row,
  output logic       frame_done,
  output logic       err_overrun
`ifdef WIN_BORDER_FLAG_EN
  ,
  output logic       win_border
`endif
);
  typedef enum logic [2:0] {IDLE, RST_FIFO, WAIT_BUSY, STREAM, FLUSH, DONE} state_t;
  localparam logic [17:0] TOTAL   = 18'(PIC_WIDTH * PIC_HEIGHT);
  localparam logic [17:0] FLUSH_N = 18'(FLUSH_ROWS * PIC_WIDTH);
  localparam logic [17:0] RST_N   = 18'(RST_CYCLES);
  localparam logic [8:0]  COL_MAX = 9'(PIC_WIDTH - 1);
  localparam logic [8:0]  ROW_MAX = 9'(PIC_HEIGHT - 1);
  state_t      r_state, w_next;
  logic [17:0] r_cnt;
  logic [8:0]  r_in_col, r_in_row, r_out_col, r_out_row, r_win_col, r_win_row;
  logic        r_low, r_busy, r_pix_ready, r_rst_fifo, r_rd_en, r_win_valid, r_done, r_err;
  logic        w_go, w_acc, w_last_acc, w_win;
  assign w_go       = start && (r_state == IDLE || r_state == DONE);
  assign w_acc      = pix_valid && r_pix_ready;
  assign w_last_acc = w_acc && r_cnt == TOTAL - 18'd1;
  assign w_win      = (w_acc && r_in_row != 9'd0) || w_next == FLUSH;
  assign busy        = r_busy;
  assign pix_ready   = r_pix_ready;
  assign rst_fifo    = r_rst_fifo;
  assign lb_valid_in = w_acc;
  assign rd_en_all   = r_rd_en;
  assign win_valid   = r_win_valid;
  assign win_col     = r_win_col;
  assign win_row     = r_win_row;
  assign frame_done  = r_done;
  assign err_overrun = r_err;
  // next-state: r_cnt counts cycles (RST_FIFO, FLUSH) or accepted pixels (STREAM) within the current state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = start ? RST_FIFO : IDLE;
      RST_FIFO:  w_next = (r_cnt == RST_N - 18'd1) ? WAIT_BUSY : RST_FIFO;
      WAIT_BUSY: w_next = (!fifo_rst_busy && r_low) ? STREAM : WAIT_BUSY;
      STREAM:    w_next = (r_cnt == TOTAL) ? FLUSH : STREAM;
      FLUSH:     w_next = (r_cnt == FLUSH_N - 18'd1) ? DONE : FLUSH;
      DONE:      w_next = start ? RST_FIFO : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // phase counter, busy-low history, input and output raster counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt     <= '0;
      r_low     <= 1'b0;
      r_in_col  <= '0;
      r_in_row  <= '0;
      r_out_col <= '0;
      r_out_row <= '0;
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + 18'(r_state != STREAM || w_acc);
      r_low <= r_state == WAIT_BUSY && !fifo_rst_busy;
      if (w_go) begin
        r_in_col  <= '0;
        r_in_row  <= '0;
        r_out_col <= '0;
        r_out_row <= '0;
      end else begin
        if (w_acc) begin
          r_in_col <= (r_in_col == COL_MAX) ? '0 : r_in_col + 9'd1;
          r_in_row <= r_in_row + 9'(r_in_col == COL_MAX);
        end
        if (w_win) begin
          r_out_col <= (r_out_col == COL_MAX) ? '0 : r_out_col + 9'd1;
          r_out_row <= r_out_row + 9'(r_out_col == COL_MAX);
        end
      end
    end
  // registered outputs decoded from the upcoming state; window coordinates latch the out counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_busy      <= 1'b0;
      r_pix_ready <= 1'b0;
      r_rst_fifo  <= 1'b1;
      r_rd_en     <= 1'b0;
      r_win_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_win_col   <= '0;
      r_win_row   <= '0;
    end else begin
      r_busy      <= w_next != IDLE && w_next != DONE;
      r_pix_ready <= w_next == STREAM && !w_last_acc;
      r_rst_fifo  <= w_next != RST_FIFO;
      r_rd_en     <= w_next == FLUSH;
      r_win_valid <= w_win;
      r_done      <= w_next == DONE;
      r_err       <= !w_go && (r_err || (pix_valid && !r_pix_ready && r_busy));
      if (w_win) begin
        r_win_col <= r_out_col;
        r_win_row <= r_out_row;
      end
    end
`ifdef WIN_BORDER_FLAG_EN
  logic r_border;
  assign win_border = r_border;
  // border flag for the window centre being issued
  always_ff @(posedge clk or posedge rst)
    if (rst) r_border <= 1'b0;
    else if (w_win) r_border <= r_out_col == '0 || r_out_col == COL_MAX || r_out_row == '0 || r_out_row == ROW_MAX;
`endif
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: table-driven and randomized frame checks against a cycle-indexed reference model
module tb_line_buffer_ctrl;
  localparam int W = 4;
  localparam int H = 3;
  localparam int R = 8;
  localparam int FR = 1;
  localparam int TOTAL = W * H;
  localparam int FLN = FR * W;
  localparam int BOUND = 400;

  logic clk = 1'b0;
  logic rst, start, pix_valid, fifo_rst_busy;
  logic busy, pix_ready, rst_fifo, lb_valid_in, rd_en_all, win_valid, frame_done, err_overrun;
  logic [8:0] win_col, win_row;
`ifdef WIN_BORDER_FLAG_EN
  logic win_border;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  line_buffer_ctrl #(.PIC_WIDTH(W), .PIC_HEIGHT(H), .RST_CYCLES(R), .FLUSH_ROWS(FR)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .rst_fifo(rst_fifo), .fifo_rst_busy(fifo_rst_busy), .lb_valid_in(lb_valid_in), .rd_en_all(rd_en_all),
    .win_valid(win_valid), .win_col(win_col), .win_row(win_row), .frame_done(frame_done),
    .err_overrun(err_overrun)
`ifdef WIN_BORDER_FLAG_EN
    , .win_border(win_border)
`endif
  );

  typedef struct {
    int duty;
    bit early;
    int restart;
    int bdly;
    int blen;
    int exp_wins;
    int exp_rd;
    int exp_rlow;
    bit exp_err;
  } scen_t;

  typedef struct {
    bit pv;
    bit fb;
    bit exp_lb;
    bit exp_busy;
    bit exp_err;
  } idle_t;

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, want);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".pix_ready"}, pix_ready, 0);
    chk({tag, ".rst_fifo"}, rst_fifo, 1);
    chk({tag, ".lb_valid_in"}, lb_valid_in, 0);
    chk({tag, ".rd_en_all"}, rd_en_all, 0);
    chk({tag, ".win_valid"}, win_valid, 0);
    chk({tag, ".win_col"}, win_col, 0);
    chk({tag, ".win_row"}, win_row, 0);
    chk({tag, ".frame_done"}, frame_done, 0);
    chk({tag, ".err_overrun"}, err_overrun, 0);
  endtask

  // t counts cycles from the start pulse; expectations follow from when the FIFO is ready and how many pixels were taken
  task automatic run_frame(input scen_t s);
    int t = 0;
    int ready_at = 1 << 30;
    int fl0 = 1 << 30;
    int done_t = BOUND;
    int lowrun = 0;
    int acc = 0;
    int wins = 0;
    int rdc = 0;
    int rlow = 0;
    bit win_due = 0;
    bit m_err = 0;
    bit rdy, pv, fb, exp_win;
    while (t <= done_t && t < BOUND) begin
      rdy = t >= ready_at && acc < TOTAL;
      exp_win = win_due || (t >= fl0 && t < fl0 + FLN);
      if (t > 0) begin
        chk("busy", busy, t < done_t);
        chk("rst_fifo", rst_fifo, !(t >= 1 && t <= R));
        chk("pix_ready", pix_ready, rdy);
        chk("rd_en_all", rd_en_all, t >= fl0 && t < fl0 + FLN);
        chk("frame_done", frame_done, t == done_t);
        chk("err_overrun", err_overrun, m_err);
        chk("win_valid", win_valid, exp_win);
        if (exp_win && win_valid) begin
          chk("win_row", win_row, wins / W);
          chk("win_col", win_col, wins % W);
`ifdef WIN_BORDER_FLAG_EN
          chk("win_border", win_border, wins / W == 0 || wins / W == H - 1 || wins % W == 0 || wins % W == W - 1);
`endif
        end
      end
      wins += int'(win_valid);
      rdc += int'(rd_en_all);
      rlow += int'(!rst_fifo);
      fb = t >= R + 1 + s.bdly && t < R + 1 + s.bdly + s.blen;
      pv = (rdy && ((s.duty == 0) ? ($urandom_range(0, 1) == 1) : ((t - ready_at) % s.duty == 0)))
           || (s.early && t >= 1 && t <= R);
      start = (t == 0) || (s.restart > 0 && t == s.restart);
      pix_valid = pv;
      fifo_rst_busy = fb;
      #1;
      chk("lb_valid_in", lb_valid_in, pv && rdy);
      if (t >= R + 1) begin
        lowrun = fb ? 0 : lowrun + 1;
        if (lowrun == 2 && ready_at > t) ready_at = t + 1;
      end
      m_err = t > 0 && (m_err || (pv && !rdy && t < done_t));
      win_due = pv && rdy && acc >= W;
      if (pv && rdy) begin
        acc++;
        if (acc == TOTAL) begin
          fl0 = t + 2;
          done_t = t + 2 + FLN;
        end
      end
      @(posedge clk);
      #1;
      t++;
    end
    start = 0;
    pix_valid = 0;
    fifo_rst_busy = 0;
    chk("frame_end", t, done_t + 1);
    chk("win_count", wins, s.exp_wins);
    chk("rd_cycles", rdc, s.exp_rd);
    chk("rst_low_cycles", rlow, s.exp_rlow);
    chk("err_final", err_overrun, s.exp_err);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    scen_t scen[6];
    idle_t idle[4];
    scen[0] = '{1, 0, 0, 0, 0, TOTAL, FLN, R, 0};
    scen[1] = '{1, 0, 0, 1, 3, TOTAL, FLN, R, 0};
    scen[2] = '{3, 0, 0, 0, 1, TOTAL, FLN, R, 0};
    scen[3] = '{1, 1, R + 8, 0, 0, TOTAL, FLN, R, 1};
    scen[4] = '{0, 0, 0, 2, 2, TOTAL, FLN, R, 0};
    scen[5] = '{0, 0, R + 12, 0, 4, TOTAL, FLN, R, 0};
    idle[0] = '{1, 0, 0, 0, 0};
    idle[1] = '{1, 1, 0, 0, 0};
    idle[2] = '{0, 1, 0, 0, 0};
    idle[3] = '{1, 0, 0, 0, 0};
    rst = 1;
    start = 0;
    pix_valid = 0;
    fifo_rst_busy = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_reset("por");
    for (int i = 0; i < 4; i++) begin
      pix_valid = idle[i].pv;
      fifo_rst_busy = idle[i].fb;
      #1 chk("idle_lb", lb_valid_in, idle[i].exp_lb);
      @(posedge clk);
      #1;
      chk("idle_busy", busy, idle[i].exp_busy);
      chk("idle_err", err_overrun, idle[i].exp_err);
    end
    pix_valid = 0;
    fifo_rst_busy = 0;
    for (int i = 0; i < 6; i++) run_frame(scen[i]);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int i = 0; i < 40 && !pix_ready; i++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_ready", pix_ready, 1);
    pix_valid = 1;
    repeat (6) @(posedge clk);
    #3;
    chk("pre_abort_col", win_col, 1);
    chk("pre_abort_busy", busy, 1);
    rst = 1;
    #1 check_reset("abort");
    pix_valid = 0;
    @(posedge clk);
    #1 rst = 0;
    run_frame(scen[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Frame-level sequencer for the 3-row line buffer used by the morphological filters. It resets the line FIFOs, waits for their reset to finish, then gates the incoming pixel stream into the buffer. At end of frame it drains the buffer with a global read enable and reports the coordinates of the 3x3 window centre produced each cycle.

Parameters:
PIC_WIDTH, 250, pixels per line (1..511)
PIC_HEIGHT, 250, lines per frame (2..511)
RST_CYCLES, 8, cycles rst_fifo is held low (>=1)
FLUSH_ROWS, 1, rows drained after the last input pixel

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse; begins a frame, ignored unless busy=0
busy  output  1  high from accepted start until frame_done
pix_valid  input  1  upstream pixel strobe
pix_ready  output  1  controller accepts pixels (STREAM only)
rst_fifo  output  1  active-low line-FIFO reset, to the line buffer
fifo_rst_busy  input  1  line-FIFO reset busy, from the line buffer
lb_valid_in  output  1  line-buffer write enable = pix_valid & pix_ready
rd_en_all  output  1  line-buffer global read enable (FLUSH only)
win_valid  output  1  window centre valid this cycle
win_col  output  9  centre column, 0..PIC_WIDTH-1
win_row  output  9  centre row, 0..PIC_HEIGHT-1
frame_done  output  1  one-cycle pulse after last window
err_overrun  output  1  sticky: pix_valid seen while pix_ready=0 and busy=1

Behaviour:
- Reset values: busy=0, pix_ready=0, rst_fifo=1, lb_valid_in=0, rd_en_all=0, win_valid=0, win_col=0, win_row=0, frame_done=0, err_overrun=0. FSM enters IDLE.
- All outputs are registered except lb_valid_in, which is combinational from pix_valid.
- States: IDLE, RST_FIFO, WAIT_BUSY, STREAM, FLUSH, DONE.
- IDLE: when start=1, go to RST_FIFO, set busy=1, clear err_overrun, and zero all counters.
- RST_FIFO: rst_fifo=0 for exactly RST_CYCLES cycles. Then set rst_fifo=1 and go to WAIT_BUSY.
- WAIT_BUSY: stay until fifo_rst_busy has been 0 for 2 consecutive cycles, then go to STREAM. This covers busy asserting late after the reset edge.
- STREAM: pix_ready=1. Each accepted pixel advances in_col (0..PIC_WIDTH-1, wraps) and in_row on wrap.
  - When the accept count reaches PIC_WIDTH*PIC_HEIGHT, go to FLUSH on the next cycle with pix_ready=0. The last pixel is accepted.
- Window tracking: the first window centre (row 0, col 0) is valid once row 1 starts filling.
  - win_valid=1 on each accepted pixel with in_row>=1, registered with 1-cycle latency.
  - win_col/win_row form a separate out counter pair that advances on each win_valid.
- FLUSH: rd_en_all=1 and win_valid=1 every cycle for FLUSH_ROWS*PIC_WIDTH cycles; the out counters keep advancing. Then go to DONE.
  - The out counters must reach (PIC_HEIGHT-1, PIC_WIDTH-1) on the final FLUSH cycle.
- DONE: frame_done=1 for one cycle, busy=0, back to IDLE.
- start while busy=1: ignored, with no side effects.
- pix_valid outside STREAM while busy=1: the pixel is not written (lb_valid_in=0) and err_overrun is set. In IDLE, pix_valid is ignored and no error is raised.
- Async rst mid-frame: everything returns to reset values immediately. rst_fifo=1 at reset; the next start re-runs the FIFO reset.
- Counter widths are 9 bits; the total pixel count uses 18 bits. No overflow is possible within the parameter ranges.

Optional Feature:
Macro WIN_BORDER_FLAG_EN.
- Defined: adds output win_border (1 bit), registered alongside win_valid. It is 1 when win_col is 0 or PIC_WIDTH-1, or win_row is 0 or PIC_HEIGHT-1, so downstream can substitute padding.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then start, PIC_WIDTH=4, PIC_HEIGHT=3, RST_CYCLES=8 -> rst_fifo low exactly 8 cycles; pix_ready stays 0 until fifo_rst_busy has been low 2 cycles.
- Continuous pix_valid for 12 pixels -> first win_valid on the cycle after pixel 5 (row 1, col 0) is accepted, with win_row=0, win_col=0; pix_ready drops after pixel 12.
- FLUSH phase -> rd_en_all high exactly 4 cycles; final window (2,3); frame_done pulses one cycle later; busy returns to 0. Total win_valid count = 12.
- Bursty pix_valid (1-in-3 duty) -> same 12 windows in order; no win_valid on idle cycles.
- pix_valid held during RST_FIFO, plus a second start mid-frame -> lb_valid_in=0, err_overrun=1 and stays sticky; frame continues unaffected.
- Assert rst during STREAM, then start again -> all outputs at reset values; the new frame completes with exactly 12 windows starting at (0,0).
